// File: rtl/frame_tx_scheduler.sv
// Frame transmit scheduler: owns the ping-pong bank selection between the
// capture writer and the transmit path, reads a captured frame byte by byte,
// and hands each byte to the UART transmitter with a start/busy handshake.
// Every frame goes out as SYNC0, SYNC1, then the payload, with a guard
// interval of idle cycles before and after it.
module frame_tx_scheduler #(
  parameter int          ADDR_W          = 15,
  parameter int          BYTES_PER_FRAME = 9216,
  parameter int          GUARD_CYCLES    = 62500000,
  parameter logic [7:0]  SYNC0           = 8'hAA,
  parameter logic [7:0]  SYNC1           = 8'h55
) (
  input  logic              Clk,
  input  logic              i_Rst,
  input  logic              i_Capture_Done,
  output logic              o_Write_Bank,
  output logic              o_Read_Bank,
  output logic [ADDR_W-1:0] o_Read_Adress,
  output logic              o_Read_Enable,
  input  logic [7:0]        i_RAM_Data,
  output logic [7:0]        o_Tx_Data,
  output logic              o_Tx_Start,
  input  logic              i_Tx_Busy,
  output logic              o_Frame_Indicator,
  output logic [7:0]        o_Frames_Dropped
);

  localparam int CNT_W = 26;

  typedef enum logic [3:0] {
    IDLE, GUARD_PRE, HDR, RD, LOAD, SEND, WAIT_HI, WAIT_LO, GUARD_POST
  } state_t;

  state_t              r_State;
  state_t              w_Next_State;
  logic [CNT_W-1:0]    r_Cycle_Cnt;
  logic                r_Hdr_Idx;
  logic                r_In_Payload;
  logic                r_Pending;
  logic                r_Write_Bank;
  logic                r_Read_Bank;
  logic [ADDR_W-1:0]   r_Read_Adress;
  logic                r_Read_Enable;
  logic [7:0]          r_Tx_Data;
  logic                r_Tx_Start;
  logic                r_Frame_Indicator;
  logic [7:0]          r_Frames_Dropped;
  logic                w_Guard_Done;
  logic                w_Last_Byte;
  logic                w_Start_Next;
  logic                w_Read_En_Next;
  logic                w_Frame_Ind_Next;

  assign w_Guard_Done = (r_Cycle_Cnt == CNT_W'(GUARD_CYCLES - 1));
  assign w_Last_Byte  = (r_Read_Adress == ADDR_W'(BYTES_PER_FRAME - 1));

  // State register
  always_ff @(posedge Clk or posedge i_Rst) begin
    if (i_Rst) r_State <= IDLE;
    else       r_State <= w_Next_State;
  end

  // Next-state logic: frame sequencing and the Tx start/busy handshake
  always_comb begin
    w_Next_State = r_State;
    unique case (r_State)
      IDLE:       if (r_Pending || i_Capture_Done) w_Next_State = GUARD_PRE;
      GUARD_PRE:  if (w_Guard_Done) w_Next_State = HDR;
      HDR:        w_Next_State = SEND;
      RD:         w_Next_State = LOAD;
      LOAD:       w_Next_State = SEND;
      SEND:       if (!i_Tx_Busy) w_Next_State = WAIT_HI;
      WAIT_HI:    if (i_Tx_Busy) w_Next_State = WAIT_LO;
      WAIT_LO: begin
        if (!i_Tx_Busy) begin
          if (!r_In_Payload && !r_Hdr_Idx) w_Next_State = HDR;
          else if (r_In_Payload && w_Last_Byte) w_Next_State = GUARD_POST;
          else w_Next_State = RD;
        end
      end
      GUARD_POST: if (w_Guard_Done) w_Next_State = IDLE;
      default:    w_Next_State = IDLE;
    endcase
  end

  // Output decode; the strobes are registered so they leave the block glitch-free
  always_comb begin
    w_Start_Next     = (r_State == SEND) && !i_Tx_Busy;
    w_Read_En_Next   = (w_Next_State == RD);
    w_Frame_Ind_Next = (w_Next_State == IDLE);
  end

  // Datapath: banks, pending/drop bookkeeping, counters, address and Tx byte
  always_ff @(posedge Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_Cycle_Cnt       <= '0;
      r_Hdr_Idx         <= 1'b0;
      r_In_Payload      <= 1'b0;
      r_Pending         <= 1'b0;
      r_Write_Bank      <= 1'b0;
      r_Read_Bank       <= 1'b1;
      r_Read_Adress     <= '0;
      r_Read_Enable     <= 1'b0;
      r_Tx_Data         <= 8'h00;
      r_Tx_Start        <= 1'b0;
      r_Frame_Indicator <= 1'b1;
      r_Frames_Dropped  <= 8'h00;
    end else begin
      r_Tx_Start        <= w_Start_Next;
      r_Read_Enable     <= w_Read_En_Next;
      r_Frame_Indicator <= w_Frame_Ind_Next;

      // Banks only swap when leaving IDLE, so a frame in flight is never disturbed.
      // A capture outside IDLE becomes pending; a second one means the writer
      // overwrote a frame that was never sent.
      if (r_State == IDLE) begin
        if (r_Pending || i_Capture_Done) begin
          r_Read_Bank  <= r_Write_Bank;
          r_Write_Bank <= ~r_Write_Bank;
          r_Pending    <= 1'b0;
          r_Cycle_Cnt  <= '0;
        end
      end else if (i_Capture_Done) begin
        if (!r_Pending) r_Pending <= 1'b1;
        else if (r_Frames_Dropped != 8'hFF) r_Frames_Dropped <= r_Frames_Dropped + 8'd1;
      end

      case (r_State)
        GUARD_PRE: begin
          if (w_Guard_Done) begin
            r_Cycle_Cnt  <= '0;
            r_Hdr_Idx    <= 1'b0;
            r_In_Payload <= 1'b0;
          end else begin
            r_Cycle_Cnt <= r_Cycle_Cnt + CNT_W'(1);
          end
        end
        GUARD_POST: begin
          if (w_Guard_Done) r_Cycle_Cnt <= '0;
          else              r_Cycle_Cnt <= r_Cycle_Cnt + CNT_W'(1);
        end
        HDR:  r_Tx_Data <= r_Hdr_Idx ? SYNC1 : SYNC0;
        LOAD: r_Tx_Data <= i_RAM_Data;
        WAIT_LO: begin
          if (!i_Tx_Busy) begin
            if (!r_In_Payload) begin
              if (!r_Hdr_Idx) begin
                r_Hdr_Idx <= 1'b1;
              end else begin
                r_In_Payload  <= 1'b1;
                r_Read_Adress <= '0;
              end
            end else if (w_Last_Byte) begin
              r_Read_Adress <= '0;
              r_Cycle_Cnt   <= '0;
            end else begin
              r_Read_Adress <= r_Read_Adress + ADDR_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_Write_Bank      = r_Write_Bank;
  assign o_Read_Bank       = r_Read_Bank;
  assign o_Read_Adress     = r_Read_Adress;
  assign o_Read_Enable     = r_Read_Enable;
  assign o_Tx_Data         = r_Tx_Data;
  assign o_Tx_Start        = r_Tx_Start;
  assign o_Frame_Indicator = r_Frame_Indicator;
  assign o_Frames_Dropped  = r_Frames_Dropped;

endmodule

// File: doc/frame_tx_scheduler.md
Name: frame_tx_scheduler

Overview:
Sequences transfer of captured camera frames from a two-bank (ping-pong) frame RAM to the UART transmitter. It owns bank selection between the capture writer and the transmit path, and generates RAM read addresses. It frames each transfer with guard intervals and a 2-byte sync header, and paces bytes with a start/busy handshake to the Tx block.

Parameters:
ADDR_W, 15, RAM address width per bank
BYTES_PER_FRAME, 9216, payload bytes per frame
GUARD_CYCLES, 62500000, idle Clk cycles before and after each frame (counter 26 bits)
SYNC0, 8'hAA, first header byte
SYNC1, 8'h55, second header byte

Ports:
Clk  in  1  system clock; all logic on rising edge
i_Rst  in  1  asynchronous reset, active-high
i_Capture_Done  in  1  one-cycle pulse from capture writer: frame complete in o_Write_Bank
o_Write_Bank  out  1  bank the capture writer must write
o_Read_Bank  out  1  bank the scheduler reads
o_Read_Adress  out  ADDR_W  RAM read address within o_Read_Bank
o_Read_Enable  out  1  RAM read strobe; data valid on i_RAM_Data next cycle
i_RAM_Data  in  8  RAM read data
o_Tx_Data  out  8  byte to transmit; stable from o_Tx_Start until i_Tx_Busy falls
o_Tx_Start  out  1  one-cycle start pulse to Tx
i_Tx_Busy  in  1  high while Tx shifts a byte
o_Frame_Indicator  out  1  high only in IDLE
o_Frames_Dropped  out  8  saturating count of frames overwritten before transmission

Behaviour:
- Reset (async): state IDLE; o_Write_Bank=0, o_Read_Bank=1, o_Read_Adress=0, o_Read_Enable=0, o_Tx_Data=0, o_Tx_Start=0, o_Frame_Indicator=1, o_Frames_Dropped=0, pending=0, counters=0. Reset mid-frame aborts immediately; no partial-byte completion.
- States: IDLE, GUARD_PRE, HDR, RD, LOAD, SEND, WAIT_HI, WAIT_LO, GUARD_POST.
- IDLE: if pending or i_Capture_Done: swap banks (o_Read_Bank<=o_Write_Bank, o_Write_Bank<=~o_Write_Bank), clear pending, cycle counter=0 -> GUARD_PRE.
- GUARD_PRE/GUARD_POST: count GUARD_CYCLES cycles (counter 0..GUARD_CYCLES-1), then -> HDR (byte index 0) / IDLE.
- HDR: o_Tx_Data<=SYNC0 (index 0) or SYNC1 (index 1) -> SEND.
- RD: o_Read_Enable=1 for exactly one cycle at o_Read_Adress -> LOAD.
- LOAD: o_Tx_Data<=i_RAM_Data -> SEND.
- SEND: when i_Tx_Busy=0 pulse o_Tx_Start one cycle -> WAIT_HI; if busy, hold.
- WAIT_HI: wait i_Tx_Busy=1 -> WAIT_LO. WAIT_LO: wait i_Tx_Busy=0, then: header index 0 -> HDR index 1; header index 1 -> RD with address 0; payload with address < BYTES_PER_FRAME-1 -> address+1, RD; last payload byte -> address<=0, counter=0, GUARD_POST.
- Byte order per frame: SYNC0, SYNC1, addresses 0..BYTES_PER_FRAME-1; exactly BYTES_PER_FRAME+2 start pulses.
- Bank rules: o_Read_Bank and o_Write_Bank are always complementary. Banks change only on the IDLE transition; never during transmission.
- i_Capture_Done outside IDLE: if pending=0, set pending=1. If pending=1 already, increment o_Frames_Dropped (saturate at 255); pending stays 1 (newest data overwrote the write bank).
- i_Capture_Done in the same cycle GUARD_POST ends: counts as pending (no drop). IDLE then starts the next frame on the following cycle.
- Latency: i_Capture_Done in IDLE -> bank swap next edge; first o_Tx_Start at GUARD_CYCLES+2 cycles after entering GUARD_PRE (Tx idle).
- o_Frame_Indicator=1 in IDLE, 0 in all other states (registered).

Test Plan:
- Reset: assert i_Rst mid-WAIT_LO -> all outputs at reset values same cycle; o_Write_Bank=0, o_Read_Bank=1.
- Single frame (GUARD_CYCLES=10, BYTES_PER_FRAME=4, Tx model busy 5 cycles after start): i_Capture_Done in IDLE -> banks swap to W=1/R=0; Tx receives AA,55,RAM[0..3]; 6 start pulses; back to IDLE with o_Frame_Indicator=1 after 10 post-guard cycles.
- Read timing: each o_Read_Enable is exactly 1 cycle; o_Tx_Data equals RAM content at o_Read_Adress the cycle after; address wraps to 0 after last byte.
- Back-pressure: hold i_Tx_Busy=1 before SEND -> no o_Tx_Start until busy drops; o_Tx_Data stable throughout.
- Overrun: three i_Capture_Done pulses during one transmission -> pending=1, o_Frames_Dropped=2. Next frame starts immediately after GUARD_POST with swapped banks. 257 further drops -> counter holds 255.
- Coincident: i_Capture_Done on final GUARD_POST cycle -> no drop; IDLE lasts one cycle; new frame begins.
